// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One radix-2 step per cycle; signs are stripped on entry and reapplied in FIX.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply keeps {partial product, remaining multiplier} in prod_q;
  // divide keeps the developing quotient in the low half of prod_q.
  assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign shifted = {rem_q, prod_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd_q};

  assign mul_res = qneg_q ? -prod_q : prod_q;
  assign quo_res = qneg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_res = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (start) begin
          state_d  = RUN;
          cnt_d    = CW'(WIDTH);
          is_div_d = op[1];
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          bzero_d  = (b == '0);
          dbz_d    = 1'b0;
          rem_d    = '0;
          if (op[1]) begin
            opnd_d = b_mag;
            prod_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
          if (is_div_q) begin
            rem_d              = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            prod_d = {add_sum, prod_q[WIDTH-1:1]};
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = mul_res;
          end else if (bzero_q) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed bench for mips_muldiv_unit at WIDTH 32 and 8
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int compared = 0;
  int mismatched = 0;
  int lat, bcnt, dcnt;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(1'b0), .mthi(1'b0), .mtlo(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the sample after the start edge until done is seen.
  task automatic wait_done(input bit narrow, output int n);
    n = 0;
    while (!(narrow ? done8 : done) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz",  64'(dbz),  64'd0);
    check("reset_hilo", {hi, lo},  64'd0);

    // MULTU max x max, counting busy cycles
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bcnt = 0; lat = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check("multu_busy_cycles", 64'(bcnt), 64'd33);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_busy_at_done", 64'(busy), 64'd0);
    check("multu_result", {hi, lo}, 64'hFFFFFFFE_00000001);
    tick();
    check("multu_done_one_cycle", 64'(done), 64'd0);

    // MULT -3 x 5, then DIV -7 / 2 launched in the done cycle
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(1'b0, lat);
    check("mult_neg_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    check("div_b2b_busy", 64'(busy), 64'd1);
    wait_done(1'b0, lat);
    check("div_b2b_latency", 64'(lat), 64'd33);
    check("div_neg_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, lat);
    check("div_minneg_result", {hi, lo}, 64'h00000000_80000000);
    check("div_minneg_no_flag", 64'(dbz), 64'd0);

    // MTHI/MTLO then divide by zero
    mthi = 1'b1; wdata = 32'h12345678;
    tick();
    mthi = 1'b0;
    check("mthi_write", 64'(hi), 64'h12345678);
    mtlo = 1'b1; wdata = 32'h9ABCDEF0;
    tick();
    mtlo = 1'b0;
    check("mtlo_write", 64'(lo), 64'h9ABCDEF0);
    issue(2'b11, 32'd7, 32'd0);
    wait_done(1'b0, lat);
    check("dbz_latency", 64'(lat), 64'd33);
    check("dbz_flag", 64'(dbz), 64'd1);
    check("dbz_hilo_kept", {hi, lo}, 64'h12345678_9ABCDEF0);
    tick();
    check("dbz_flag_holds", 64'(dbz), 64'd1);

    // DIVU 100 / 7 flushed on its 10th busy cycle
    issue(2'b11, 32'd100, 32'd7);
    check("dbz_cleared_by_start", 64'(dbz), 64'd0);
    repeat (9) tick();
    check("flush_still_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_low", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h12345678_9ABCDEF0);

    // Same operation aborted by reset
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);

    // MTHI and MTLO together
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);

    // MULTU in flight; start and mthi mid-run are ignored
    issue(2'b01, 32'h1234, 32'h5678);
    repeat (5) tick();
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; mthi = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; mthi = 1'b0;
    wait_done(1'b0, lat);
    check("midrun_latency", 64'(lat + 6), 64'd33);
    check("midrun_result", {hi, lo}, 64'h00000000_06260060);
    tick();
    check("midrun_start_not_queued", 64'(busy), 64'd0);

    // start and flush together in IDLE
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle_busy", 64'(busy), 64'd0);
    tick();
    check("start_flush_idle_done", 64'(done), 64'd0);
    check("start_flush_idle_hilo", {hi, lo}, 64'h00000000_06260060);

    // WIDTH = 8 instance
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, lat);
    check("w8_mult_latency", 64'(lat), 64'd9);
    check("w8_mult_result", {48'd0, hi8, lo8}, 64'h4000);
    start8 = 1'b1; op8 = 2'b10; a8 = 8'h81; b8 = 8'h03;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, lat);
    check("w8_div_latency", 64'(lat), 64'd9);
    check("w8_div_result", {48'd0, hi8, lo8}, 64'hFFD6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
